l1_data_cache: RTL and testbench



---
 rtl/l1_data_cache.sv | 164 ++++++++++++++++
 tb/tb_l1_data_cache.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/l1_data_cache.sv
// Direct-mapped, write-through, no-write-allocate L1 data cache with one-word lines.
// Loads that hit complete in the request cycle. Load misses and all stores go
// through a req/ack handshake to the next-level memory, then spend one DONE cycle.
module l1_data_cache #(
  parameter int unsigned INDEX_BITS = 6
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        core_enabled_i,
  input  logic [29:0] core_address_i,
  input  logic [3:0]  core_write_en_i,
  input  logic [31:0] core_data_i,
  output logic [31:0] core_data_o,
  output logic        core_blocking_n_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [29:0] mem_address_o,
  output logic [31:0] mem_wdata_o,
  output logic [3:0]  mem_wstrb_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i
);

  localparam int unsigned TAG_BITS = 30 - INDEX_BITS;
  localparam int unsigned LINES    = 32'(1) << INDEX_BITS;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_MEM_READ  = 2'd1,
    S_MEM_WRITE = 2'd2,
    S_DONE      = 2'd3
  } state_t;

  state_t                r_state;
  logic [LINES-1:0]      r_valid;
  logic [TAG_BITS-1:0]   r_tag  [LINES];
  logic [31:0]           r_data [LINES];
  logic [31:0]           r_resp;
  logic                  r_mem_req;
  logic                  r_mem_we;
  logic [29:0]           r_mem_address;
  logic [31:0]           r_mem_wdata;
  logic [3:0]            r_mem_wstrb;

  // The core address is already a word address, so the index is its low bits
  // (byte-address bits [INDEX_BITS+1:2]); the tag is everything above.
  logic [INDEX_BITS-1:0] w_index;
  logic [TAG_BITS-1:0]   w_tag;
  logic [31:0]           w_line;
  logic                  w_match;
  logic                  w_hit;
  logic                  w_store;
  logic [31:0]           w_merged;

  assign w_index = core_address_i[INDEX_BITS-1:0];
  assign w_tag   = core_address_i[29:INDEX_BITS];
  assign w_line  = r_data[w_index];
  assign w_match = r_valid[w_index] & (r_tag[w_index] == w_tag);
  assign w_hit   = core_enabled_i & w_match;
  assign w_store = |core_write_en_i;

  // Byte-strobe merge of store data into the resident line
  always_comb begin
    w_merged = w_line;
    for (int k = 0; k < 4; k++) begin
      if (core_write_en_i[k]) begin
        w_merged[8*k +: 8] = core_data_i[8*k +: 8];
      end
    end
  end

  // Core-side response: a load hit answers in the request cycle, so this is combinational
  always_comb begin
    core_blocking_n_o = 1'b1;
    core_data_o       = 32'h0;
    unique case (r_state)
      S_IDLE: begin
        if (core_enabled_i) begin
          if (!w_store && w_hit) begin
            core_data_o = w_line;
          end else begin
            core_blocking_n_o = 1'b0;
          end
        end
      end
      S_MEM_READ, S_MEM_WRITE: core_blocking_n_o = 1'b0;
      S_DONE: core_data_o = r_resp;
      default: ;
    endcase
  end

  // Control FSM with registered next-level request, valid bits and response register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state       <= S_IDLE;
      r_valid       <= '0;
      r_resp        <= 32'h0;
      r_mem_req     <= 1'b0;
      r_mem_we      <= 1'b0;
      r_mem_address <= 30'h0;
      r_mem_wdata   <= 32'h0;
      r_mem_wstrb   <= 4'h0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (core_enabled_i) begin
            if (w_store) begin
              r_state       <= S_MEM_WRITE;
              r_mem_req     <= 1'b1;
              r_mem_we      <= 1'b1;
              r_mem_address <= core_address_i;
              r_mem_wdata   <= core_data_i;
              r_mem_wstrb   <= core_write_en_i;
            end else if (!w_hit) begin
              r_state       <= S_MEM_READ;
              r_mem_req     <= 1'b1;
              r_mem_we      <= 1'b0;
              r_mem_address <= core_address_i;
              r_mem_wdata   <= 32'h0;
              r_mem_wstrb   <= 4'h0;
            end
          end
        end
        S_MEM_READ: begin
          if (mem_ack_i) begin
            r_state          <= S_DONE;
            r_valid[w_index] <= 1'b1;
            r_resp           <= mem_rdata_i;
            r_mem_req        <= 1'b0;
            r_mem_we         <= 1'b0;
          end
        end
        S_MEM_WRITE: begin
          if (mem_ack_i) begin
            r_state   <= S_DONE;
            r_mem_req <= 1'b0;
            r_mem_we  <= 1'b0;
          end
        end
        S_DONE: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Tag/data arrays: refill on read ack, byte merge on write ack only when the line hits
  always_ff @(posedge clk_i) begin
    if (!rst_i && mem_ack_i) begin
      if (r_state == S_MEM_READ) begin
        r_tag[w_index]  <= w_tag;
        r_data[w_index] <= mem_rdata_i;
      end else if (r_state == S_MEM_WRITE && w_match) begin
        r_data[w_index] <= w_merged;
      end
    end
  end

  assign mem_req_o     = r_mem_req;
  assign mem_we_o      = r_mem_we;
  assign mem_address_o = r_mem_address;
  assign mem_wdata_o   = r_mem_wdata;
  assign mem_wstrb_o   = r_mem_wstrb;

endmodule

// File: tb/tb_l1_data_cache.sv
// Directed bench for l1_data_cache: refill, hit, full and partial stores,
// no-allocate, index-conflict eviction and reset during a refill.
module tb_l1_data_cache;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        core_enabled_i = 1'b0;
  logic [29:0] core_address_i = 30'h0;
  logic [3:0]  core_write_en_i = 4'h0;
  logic [31:0] core_data_i = 32'h0;
  logic [31:0] core_data_o;
  logic        core_blocking_n_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [29:0] mem_address_o;
  logic [31:0] mem_wdata_o;
  logic [3:0]  mem_wstrb_o;
  logic        mem_ack_i = 1'b0;
  logic [31:0] mem_rdata_i = 32'h0;

  int errors = 0;
  int checks = 0;

  // Results of the most recent access
  int          a_low;
  logic [31:0] a_data;
  logic        a_req_seen;
  logic        a_req_we;
  logic [29:0] a_req_addr;
  logic [31:0] a_req_wdata;
  logic [3:0]  a_req_wstrb;

  l1_data_cache #(.INDEX_BITS(6)) dut (
    .clk_i             (clk_i),
    .rst_i             (rst_i),
    .core_enabled_i    (core_enabled_i),
    .core_address_i    (core_address_i),
    .core_write_en_i   (core_write_en_i),
    .core_data_i       (core_data_i),
    .core_data_o       (core_data_o),
    .core_blocking_n_o (core_blocking_n_o),
    .mem_req_o         (mem_req_o),
    .mem_we_o          (mem_we_o),
    .mem_address_o     (mem_address_o),
    .mem_wdata_o       (mem_wdata_o),
    .mem_wstrb_o       (mem_wstrb_o),
    .mem_ack_i         (mem_ack_i),
    .mem_rdata_i       (mem_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One core access; memory acks on the lat-th cycle that mem_req_o is high.
  task automatic access(input logic [31:0] byte_addr, input logic [3:0] we,
                        input logic [31:0] wdata, input int lat, input logic [31:0] rdata);
    int  nreq;
    logic done;
    nreq = 0;
    done = 1'b0;
    a_low = 0;
    a_data = 32'hx;
    a_req_seen = 1'b0;
    @(negedge clk_i);
    core_enabled_i  = 1'b1;
    core_address_i  = byte_addr[31:2];
    core_write_en_i = we;
    core_data_i     = wdata;
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      if (cyc > 0) @(negedge clk_i);
      mem_ack_i = 1'b0;
      #1;
      if (mem_req_o) begin
        a_req_seen  = 1'b1;
        a_req_we    = mem_we_o;
        a_req_addr  = mem_address_o;
        a_req_wdata = mem_wdata_o;
        a_req_wstrb = mem_wstrb_o;
        nreq++;
        if (nreq == lat) begin
          mem_ack_i   = 1'b1;
          mem_rdata_i = rdata;
        end
      end
      if (core_blocking_n_o) begin
        a_data = core_data_o;
        done   = 1'b1;
      end else begin
        a_low++;
      end
    end
    core_enabled_i  = 1'b0;
    core_write_en_i = 4'h0;
    mem_ack_i       = 1'b0;
    chk("access_completes", 32'(done), 32'd1);
  endtask

  initial begin
    int waited;

    // Reset state
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    chk("rst_blocking_n", 32'(core_blocking_n_o), 32'd1);
    chk("rst_mem_req", 32'(mem_req_o), 32'd0);
    chk("rst_core_data", core_data_o, 32'h0);
    chk("rst_mem_bus", {mem_we_o, mem_wstrb_o, 27'(mem_address_o | 30'(mem_wdata_o))}, 32'h0);

    // Load miss, memory latency 3
    access(32'h100, 4'h0, 32'h0, 3, 32'hDEADBEEF);
    chk("miss_low_cycles", 32'(a_low), 32'd4);
    chk("miss_data", a_data, 32'hDEADBEEF);
    chk("miss_req_we", 32'(a_req_we), 32'd0);
    chk("miss_req_addr", 32'(a_req_addr), 32'h40);

    // Repeat load hits with zero wait
    access(32'h100, 4'h0, 32'h0, 1, 32'h0);
    chk("hit_low_cycles", 32'(a_low), 32'd0);
    chk("hit_data", a_data, 32'hDEADBEEF);
    chk("hit_no_req", 32'(a_req_seen), 32'd0);

    // Full-word store to cached line
    access(32'h100, 4'hF, 32'h11223344, 2, 32'h0);
    chk("st_low_cycles", 32'(a_low), 32'd3);
    chk("st_req_we", 32'(a_req_we), 32'd1);
    chk("st_req_wstrb", 32'(a_req_wstrb), 32'hF);
    chk("st_req_wdata", a_req_wdata, 32'h11223344);
    chk("st_req_addr", 32'(a_req_addr), 32'h40);
    access(32'h100, 4'h0, 32'h0, 1, 32'h0);
    chk("st_hit_low", 32'(a_low), 32'd0);
    chk("st_hit_data", a_data, 32'h11223344);

    // Partial store, byte 1 only
    access(32'h100, 4'b0010, 32'hAABBCCDD, 1, 32'h0);
    chk("pst_req_wstrb", 32'(a_req_wstrb), 32'h2);
    chk("pst_low_cycles", 32'(a_low), 32'd2);
    access(32'h100, 4'h0, 32'h0, 1, 32'h0);
    chk("pst_hit_low", 32'(a_low), 32'd0);
    chk("pst_hit_data", a_data, 32'h1122CC44);

    // Store to uncached 0x200 (same index) must not allocate nor disturb 0x100
    access(32'h200, 4'hF, 32'h12345678, 1, 32'h0);
    chk("na_req_addr", 32'(a_req_addr), 32'h80);
    access(32'h100, 4'h0, 32'h0, 1, 32'h0);
    chk("na_keep_low", 32'(a_low), 32'd0);
    chk("na_keep_data", a_data, 32'h1122CC44);
    access(32'h200, 4'h0, 32'h0, 2, 32'hCAFEF00D);
    chk("na_load_miss", 32'(a_req_seen), 32'd1);
    chk("na_load_we", 32'(a_req_we), 32'd0);
    chk("na_load_low", 32'(a_low), 32'd3);
    chk("na_load_data", a_data, 32'hCAFEF00D);

    // 0x200 refill evicted 0x100
    access(32'h100, 4'h0, 32'h0, 1, 32'h0BADF00D);
    chk("evict_low", 32'(a_low), 32'd2);
    chk("evict_data", a_data, 32'h0BADF00D);
    access(32'h200, 4'h0, 32'h0, 1, 32'h0);
    chk("evict_back_low", 32'(a_low), 32'd2);

    // Reset during MEM_READ, then a stale ack
    @(negedge clk_i);
    core_enabled_i  = 1'b1;
    core_address_i  = 30'h40;
    core_write_en_i = 4'h0;
    waited = 0;
    while (!mem_req_o && waited < 20) begin
      @(negedge clk_i);
      waited++;
    end
    chk("rstmid_req_seen", 32'(mem_req_o), 32'd1);
    rst_i = 1'b1;
    core_enabled_i = 1'b0;
    @(negedge clk_i);
    rst_i       = 1'b0;
    mem_ack_i   = 1'b1;
    mem_rdata_i = 32'h55;
    #1;
    chk("rstmid_req_dropped", 32'(mem_req_o), 32'd0);
    chk("rstmid_blocking_n", 32'(core_blocking_n_o), 32'd1);
    @(negedge clk_i);
    mem_ack_i = 1'b0;
    #1;
    chk("rstmid_idle_req", 32'(mem_req_o), 32'd0);
    chk("rstmid_idle_data", core_data_o, 32'h0);
    chk("rstmid_idle_blk", 32'(core_blocking_n_o), 32'd1);
    access(32'h100, 4'h0, 32'h0, 1, 32'h77);
    chk("rstmid_reload_low", 32'(a_low), 32'd2);
    chk("rstmid_reload_data", a_data, 32'h77);
    access(32'h200, 4'h0, 32'h0, 1, 32'h88);
    chk("rstmid_other_miss", 32'(a_req_seen), 32'd1);

    @(negedge clk_i);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
